score_display: RTL
==================

# score_display

Downstream consumer of the two 4-bit player scores produced by the scoreboard. It time-multiplexes both scores onto a 4-digit common-anode seven-segment display in the form P1 - - P2. It latches and blinks the winning score, and emits a fixed-length active-low buzzer pulse on every score change. Score inputs come from edge-clocked logic outside `i_clk`, so this block synchronises them before use.

## Interface
- `REFRESH_DIV`, default 100000: `i_clk` cycles each digit is driven. Minimum 2.
- `BLINK_DIV`, default 25000000: `i_clk` cycles per blink half-period.
- `BUZZ_CYCLES`, default 10000000: buzzer pulse length in `i_clk` cycles. Minimum 1.
- `WIN_SCORE`, default 5: score value that declares a winner.
- `i_clk` in 1: system clock. This is the only clock in the block.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_score_player_1` in 4: player 1 score. Asynchronous to `i_clk`.
- `i_score_player_2` in 4: player 2 score. Asynchronous to `i_clk`.
- `o_seg` out 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `o_dp` out 1: decimal point, active-low. Held at 1.
- `o_an` out 4: digit enables, active-low, one-hot-low, registered. Digit 3 is leftmost.
- `o_winner` out 2: bit0 = player 1 has won, bit1 = player 2 has won. Registered.
- `o_buzzer` out 1: active-low buzzer drive, registered.

## Operation
- Synchroniser: each score passes through 2 flops. All logic below uses only the second-stage value `s1`/`s2`. `p1`/`p2` hold the previous-cycle `s1`/`s2`.
- Scan counter: `ref_cnt` counts 0..REFRESH_DIV-1, then wraps. At the wrap, the 2-bit `dig_idx` increments modulo 4.
- Digit mapping by `dig_idx`:
  - 0 → `o_an`=1110, shows s2.
  - 1 → `o_an`=1101, shows a dash.
  - 2 → `o_an`=1011, shows a dash.
  - 3 → `o_an`=0111, shows s1.
- Glyph encoding (`o_seg` values):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
  - Values 10..15 show E=0000110.
- Blink: `blink_cnt` counts 0..BLINK_DIV-1. At the wrap, `blink_ph` toggles. `blink_ph`=1 means hidden.
- Winner latch:
  - `o_winner[0]` sets when s1==WIN_SCORE; `o_winner[1]` sets when s2==WIN_SCORE.
  - Both bits clear only on reset or when s1==0 and s2==0 in the same cycle.
  - Set has priority over clear. This case is only reachable when WIN_SCORE==0.
- Winner blink: when the latched winner's digit is selected and `blink_ph`=1, `o_seg` is blank. `o_an` still scans normally. Dash digits never blink.
- Buzzer state machine:
  - States are IDLE and BUZZ.
  - On any cycle where (s1!=p1) or (s2!=p2): load `buzz_cnt`=BUZZ_CYCLES-1, drive `o_buzzer`=0, enter BUZZ.
  - In BUZZ, `buzz_cnt` decrements each cycle. When it is 0, return to IDLE with `o_buzzer`=1.
  - A change while in BUZZ reloads the counter, extending the pulse.
  - Both scores changing in the same cycle give a single pulse.

## Timing
- Reset values, applied in the cycle after `i_rst` is sampled high:
  - Outputs: `o_seg`=1111111, `o_an`=1111, `o_dp`=1, `o_buzzer`=1, `o_winner`=00.
  - Internal: all counters 0, `dig_idx`=0, `blink_ph`=0, sync/prev regs 0.
- Reset mid-operation aborts a buzz pulse and the blink phase immediately.
- The first cycle after reset deasserts drives `o_an`=1110 with the s2 glyph.
- Input to display latency: 2 sync cycles plus 1 output register = 3 cycles, provided the digit is selected.
- Input change to `o_buzzer` low: 3 cycles (2 sync, 1 compare/register).
- Input to `o_winner` set: 3 cycles.
- `o_an` and `o_seg` change in the same cycle. There is no glitch cycle with two digits enabled.
- Scan period is 4×REFRESH_DIV cycles. Blink period is 2×BLINK_DIV cycles.
- Post-reset sync regs are 0, so a nonzero score present at reset release causes one buzz pulse. This is intended: it is the start-of-game beep.

## Test plan
- Reset, then P1=3, P2=7, REFRESH_DIV=4:
  - `o_an` cycles 1110/1101/1011/0111, each for 4 cycles.
  - `o_seg` shows 1111000 / 0111111 / 0111111 / 0110000.
  - `o_buzzer` is low for exactly BUZZ_CYCLES cycles, starting 3 cycles after release.
- BUZZ_CYCLES=8:
  - Change P1 2→3, then change P2 after 5 cycles: one continuous low of 13 cycles.
  - Change both scores in the same cycle: one low of 8 cycles.
- P1 set to 5 (BLINK_DIV=16):
  - `o_winner`=01 after 3 cycles.
  - Digit 3 shows 0010010 while `blink_ph`=0 and 1111111 while `blink_ph`=1. The other digits are unaffected.
- After a win, P1 wraps 5→0 with P2=2: `o_winner` stays 01. Then P2 → 0: `o_winner`=00 3 cycles later.
- P1 and P2 both go to 5 in the same cycle: `o_winner`=11, and digits 3 and 0 blink in phase.
- Assert `i_rst` for 1 cycle mid-buzz with P2=12:
  - Next cycle all outputs take their reset values.
  - Afterwards digit 0 shows E=0000110, and a fresh buzz starts 3 cycles after release.

Source files
------------

// File: rtl/score_display.sv
// score_display: scans two synchronised 4-bit player scores onto a 4-digit
// common-anode seven-segment display as "P1 - - P2". It latches and blinks
// the winner and pulses an active-low buzzer whenever either score changes.
//
// Buzzer state table
//   state | meaning
//   IDLE  | buzzer released (o_buzzer = 1), waiting for a score change
//   BUZZ  | buzzer driven low, buzz_cnt counting down to release
module score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int BUZZ_CYCLES = 10000000,
    parameter int WIN_SCORE   = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_score_player_1,
    input  logic [3:0] i_score_player_2,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [3:0] o_an,
    output logic [1:0] o_winner,
    output logic       o_buzzer
);

    localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
    localparam int BUZZ_W  = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

    localparam logic [REF_W-1:0]   REF_MAX   = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE = 1'b0,
        BUZZ = 1'b1
    } buzz_state_t;

    logic [3:0] sync1_a, sync2_a;
    logic [3:0] s1, s2;
    logic [3:0] p1, p2;

    logic [REF_W-1:0]   ref_cnt;
    logic [1:0]         dig_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;

    logic [1:0] win_set;
    logic       win_clr;
    logic [1:0] winner_d;

    logic [6:0] seg_d;
    logic [3:0] an_d;

    buzz_state_t        state, state_next;
    logic [BUZZ_W-1:0]  buzz_cnt, buzz_cnt_next;
    logic               score_changed;
    logic               buzzer_d;

    // Score value to seven-segment glyph; out-of-range values show "E".
    function automatic logic [6:0] glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b0000110;
        endcase
        return g;
    endfunction

    // Two-flop synchronisers plus previous-value registers for change detect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_a <= 4'd0;
            sync2_a <= 4'd0;
            s1      <= 4'd0;
            s2      <= 4'd0;
            p1      <= 4'd0;
            p2      <= 4'd0;
        end else begin
            sync1_a <= i_score_player_1;
            sync2_a <= i_score_player_2;
            s1      <= sync1_a;
            s2      <= sync2_a;
            p1      <= s1;
            p2      <= s2;
        end
    end

    // Digit scan: dwell REFRESH_DIV cycles per digit, then advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ref_cnt <= '0;
            dig_idx <= 2'd0;
        end else if (ref_cnt == REF_MAX) begin
            ref_cnt <= '0;
            dig_idx <= dig_idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Blink phase toggles every BLINK_DIV cycles; phase 1 hides the winner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Winner set/clear terms; a set always survives a simultaneous clear.
    always_comb begin
        win_set[0] = (int'(s1) == WIN_SCORE);
        win_set[1] = (int'(s2) == WIN_SCORE);
        win_clr    = (s1 == 4'd0) && (s2 == 4'd0);
        winner_d   = (win_clr ? 2'b00 : o_winner) | win_set;
    end

    // Winner latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_winner <= 2'b00;
        end else begin
            o_winner <= winner_d;
        end
    end

    // Select the active digit's anode and glyph, blanking a blinking winner.
    always_comb begin
        an_d  = 4'b1110;
        seg_d = SEG_DASH;
        case (dig_idx)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = (o_winner[1] && blink_ph) ? SEG_BLANK : glyph(s2);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = SEG_DASH;
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = SEG_DASH;
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = (o_winner[0] && blink_ph) ? SEG_BLANK : glyph(s1);
            end
        endcase
    end

    // Register anode and segments together so they switch on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_an  <= 4'b1111;
            o_seg <= SEG_BLANK;
        end else begin
            o_an  <= an_d;
            o_seg <= seg_d;
        end
    end

    assign o_dp = 1'b1;

    assign score_changed = (s1 != p1) || (s2 != p2);

    // Buzzer FSM state and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            buzz_cnt <= '0;
            o_buzzer <= 1'b1;
        end else begin
            state    <= state_next;
            buzz_cnt <= buzz_cnt_next;
            o_buzzer <= buzzer_d;
        end
    end

    // Buzzer next state: any change (re)starts the pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (score_changed) begin
                    state_next = BUZZ;
                end
            end
            BUZZ: begin
                if (score_changed) begin
                    state_next = BUZZ;
                end else if (buzz_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Buzzer outputs: counter reload/decrement and the registered drive level.
    always_comb begin
        buzz_cnt_next = buzz_cnt;
        if (score_changed) begin
            buzz_cnt_next = BUZZ_LOAD;
        end else if ((state == BUZZ) && (buzz_cnt != '0)) begin
            buzz_cnt_next = buzz_cnt - 1'b1;
        end
        buzzer_d = (state_next == IDLE);
    end

endmodule
